// File: rtl/bus_pkg.sv
// Shared definitions for the bus controller: FSM encoding, default bus
// widths and the addresses of the two memory-mapped bus devices.
package bus_pkg;

  // Bus-cycle sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Default address and data widths of the shared bus.
  localparam int BUS_AW = 16;
  localparam int BUS_DW = 16;

  // Memory-mapped device ports on the shared bus.
  localparam logic [15:0] RD_DEV_ADDR = 16'hFFF0;
  localparam logic [15:0] WR_DEV_ADDR = 16'hFFF8;

endpackage : bus_pkg

// File: rtl/bus_arbiter_rr.sv
// Round-robin winner selection. The search starts one position above the
// last owner and wraps modulo NREQ, so the last owner has lowest priority.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  int          k;
  logic [IW-1:0] w_k;

  // First set request bit found searching upward from i_ptr+1.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // a combinational output unassigned would infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    k       = 0;
    w_k     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k   = (int'(i_ptr) + i) % NREQ;
      w_k = IW'(k);
      if (!o_valid && i_req[w_k]) begin
        o_valid      = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx        = w_k;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/bus_arbiter.sv
// Shared-bus controller: arbitrates NREQ masters round-robin, sequences one
// bus cycle at a time (ADDR setup, WAIT for device ready or timeout, RESP
// completion pulse) and returns read data or a timeout error to the owner.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = BUS_AW,
  parameter int DW      = BUS_DW,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    wr,
  input  logic [NREQ*AW-1:0] addr_in,
  input  logic [NREQ*DW-1:0] wdata_in,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               err,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      address,
  output logic               w,
  output logic [DW-1:0]      data_out,
  output logic               data_oe,
  input  logic [DW-1:0]      data_in,
  input  logic               ready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_valid;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_sel_wr;
  logic [CW-1:0]   w_cnt_next;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Route the prospective winner's address, direction and write data.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wr    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr  = addr_in[i*AW +: AW];
        w_sel_wdata = wdata_in[i*DW +: DW];
        w_sel_wr    = wr[i];
      end
    end
  end

  assign w_cnt_next = r_cnt + 1'b1;

  // Bus-cycle sequencer; all bus and master-side outputs are registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: async reset clears every register, so a cycle in flight is
    // simply abandoned: no done or err is ever produced for it.
    if (!reset_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      address  <= '0;
      w        <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of state, counter and outputs.
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state  <= ADDR;
            r_owner  <= w_idx;
            gnt      <= w_grant;
            address  <= w_sel_addr;
            w        <= w_sel_wr;
            data_out <= w_sel_wdata;
            data_oe  <= w_sel_wr;
          end else begin
            address  <= '0;
            w        <= 1'b0;
            data_out <= '0;
            data_oe  <= 1'b0;
          end
        end

        // Setup cycle: bus already driven, ready deliberately ignored.
        ADDR: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end

        // Ready takes precedence over a timeout landing in the same cycle.
        WAIT: begin
          if (ready || (w_cnt_next == CW'(TIMEOUT))) begin
            r_state <= RESP;
            done    <= gnt;
            err     <= !ready;
            address <= '0;
            w       <= 1'b0;
            data_oe <= 1'b0;
            if (ready && !w) begin
              rdata <= data_in;
            end
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        RESP: begin
          r_state  <= IDLE;
          r_ptr    <= r_owner;
          gnt      <= '0;
          done     <= '0;
          err      <= 1'b0;
          data_out <= '0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a scoreboard: each issued request
// pushes its expected completion; a monitor pops and compares on every done.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int NREQ    = 2;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  typedef struct {
    int          owner;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic               clk;
  logic               reset_n;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    wr;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ*DW-1:0] wdata_in;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      address;
  logic               w;
  logic [DW-1:0]      data_out;
  logic               data_oe;
  logic [DW-1:0]      data_in;
  logic               ready;

  logic               tie_ready;
  logic [15:0]        rd_val;
  logic [15:0]        dev_wreg = 16'h0000;
  localparam logic [15:0] TIE_DATA = 16'h5A5A;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   done_seen = 0;

  bus_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clk), .reset_n(reset_n), .req(req), .wr(wr),
    .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .address(address), .w(w),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device model: read port and write port answer at once; anything else
  // stays silent unless the bench forces ready.
  always_comb begin
    ready   = (address == RD_DEV_ADDR) || (address == WR_DEV_ADDR) || tie_ready;
    data_in = (address == RD_DEV_ADDR) ? rd_val : TIE_DATA;
  end

  always @(posedge clk) begin
    if (w && data_oe && ready && (address == WR_DEV_ADDR)) dev_wreg <= data_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int owner, input logic e, input logic [15:0] rd);
    exp_t x;
    x.owner = owner;
    x.err   = e;
    x.rdata = rd;
    exp_q.push_back(x);
    n_pushed++;
  endtask

  task automatic launch(input int m, input logic is_wr, input logic [15:0] a, input logic [15:0] d);
    wr[m]              = is_wr;
    addr_in[m*AW +: AW] = a;
    wdata_in[m*DW +: DW] = d;
    req[m]             = 1'b1;
  endtask

  // Counts negedges until a done bit in mask is seen, bounded by budget.
  task automatic wait_done(input logic [NREQ-1:0] mask, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((done & mask) == '0) && (n < budget));
    if ((done & mask) == '0) check("wait_done_budget", 32'(done), 32'(mask));
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && ((done != '0) || err)) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", {err, done}, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_done", 32'(done), 32'(2'b01 << e.owner));
          check("sb_err", 32'(err), 32'(e.err));
          check("sb_rdata", 32'(rdata), 32'(e.rdata));
        end
      end
    end
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    req       = '0;
    wr        = '0;
    addr_in   = '0;
    wdata_in  = '0;
    tie_ready = 1'b0;
    rd_val    = 16'hE3E3;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt_done_err", {gnt, done, err}, 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_bus", {address, w, data_out, data_oe}, 0);
    reset_n = 1'b1;

    // Single read by master 0.
    @(posedge clk); #1;
    launch(0, 1'b0, RD_DEV_ADDR, 16'h0000);
    push(0, 1'b0, 16'hE3E3);
    wait_done(2'b01, 10, n);
    check("read_latency", n, 4);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("read_idle_after", {gnt, done, address}, 0);

    // Single write by master 1.
    @(posedge clk); #1;
    launch(1, 1'b1, WR_DEV_ADDR, 16'h71F0);
    push(1, 1'b0, 16'hE3E3);
    repeat (2) @(negedge clk);
    check("wr_addr_phase", {gnt, address, w, data_oe, data_out}, {2'b10, WR_DEV_ADDR, 2'b11, 16'h71F0});
    @(negedge clk);
    check("wr_wait_phase", {gnt, address, w, data_oe, data_out}, {2'b10, WR_DEV_ADDR, 2'b11, 16'h71F0});
    wait_done(2'b10, 5, n);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    check("wr_dev_reg", 32'(dev_wreg), 32'h71F0);

    // Contention: both masters hold req; last owner was 1, so 0 goes first.
    @(posedge clk); #1;
    launch(0, 1'b0, RD_DEV_ADDR, 16'h0000);
    launch(1, 1'b0, RD_DEV_ADDR, 16'h0000);
    push(0, 1'b0, 16'hE3E3);
    push(1, 1'b0, 16'hE3E3);
    push(0, 1'b0, 16'hE3E3);
    push(1, 1'b0, 16'hE3E3);
    for (int k = 0; k < 4; k++) begin
      wait_done(2'b11, 10, n);
      check("cont_gnt_onehot", $countones(gnt), 1);
      check("cont_gnt_eq_done", 32'(gnt), 32'(done));
    end
    @(posedge clk); #1;
    req = '0;

    // Timeout on unmapped address; rdata must keep E3E3.
    @(posedge clk); #1;
    launch(0, 1'b0, 16'h1234, 16'h0000);
    push(0, 1'b1, 16'hE3E3);
    wait_done(2'b01, 40, n);
    check("timeout_latency", n, TIMEOUT + 3);
    @(posedge clk); #1;
    req[0] = 1'b0;

    // Ready arrives in the very cycle the counter would time out.
    @(posedge clk); #1;
    launch(0, 1'b0, 16'h1234, 16'h0000);
    push(0, 1'b0, TIE_DATA);
    repeat (16) @(posedge clk);
    #1;
    tie_ready = 1'b1;
    @(negedge clk);
    check("tie_no_early_done", 32'(done), 0);
    @(posedge clk); #1;
    tie_ready = 1'b0;
    @(negedge clk);
    check("tie_done", 32'(done), 32'b01);
    @(posedge clk); #1;
    req[0] = 1'b0;

    // Reset during WAIT: outputs clear at once, no completion is produced.
    rd_val = 16'hC0DE;
    @(posedge clk); #1;
    launch(0, 1'b0, 16'h1234, 16'h0000);
    repeat (4) @(negedge clk);
    check("pre_rst_gnt", 32'(gnt), 32'b01);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {gnt, done, err}, 0);
    check("midrst_bus", {address, w, data_out, data_oe}, 0);
    check("midrst_rdata", 32'(rdata), 0);
    addr_in[0 +: AW] = RD_DEV_ADDR;
    @(posedge clk); #1;
    reset_n = 1'b1;
    push(0, 1'b0, 16'hC0DE);
    repeat (2) @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'b01);
    wait_done(2'b01, 10, n);
    @(posedge clk); #1;
    req[0] = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    check("done_count", done_seen, n_pushed);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_bus_arbiter
